gray_ptr_rx: RTL and testbench

Receiving end of the gray-coded pointer path in the ETROC2 readout. It takes an N-bit gray-coded pointer produced in another clock domain (for example a circular-buffer write pointer) and resynchronizes it through two flops. It then decodes it to binary, reports the per-cycle advance and flags illegal multi-bit transitions. It sits on the reader side of the circular buffer and supplies the binary pointer used for occupancy and readout-address arithmetic.

---
 rtl/gray_ptr_rx_pkg.sv | 13 +
 rtl/gray_ptr_rx_g2b.sv | 14 +
 rtl/gray_ptr_rx.sv | 110 +++++++++++
 tb/tb_gray_ptr_rx.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/gray_ptr_rx_pkg.sv
// Shared definitions for the gray-pointer receiver: state encoding, fill length
// and the default pointer width (circular-buffer address width).
package gray_ptr_rx_pkg;

   localparam int unsigned PTR_W_DEF = 9;
   localparam int unsigned FILL_LEN  = 3;

   typedef enum logic {
      ST_FILL  = 1'b0,
      ST_TRACK = 1'b1
   } rx_state_e;

endpackage

// File: rtl/gray_ptr_rx_g2b.sv
// Combinational gray-to-binary decoder: each binary bit is the XOR of all gray
// bits at and above its position.
module gray_ptr_rx_g2b #(
   parameter int N = 9
) (
   input  logic [N-1:0] gray_i,
   output logic [N-1:0] bin_o
);

   for (genvar i = 0; i < N; i++) begin : g_bit
      assign bin_o[i] = ^(gray_i >> i);
   end

endmodule

// File: rtl/gray_ptr_rx.sv
// Reader-side receiver for a gray-coded pointer from another clock domain:
// two-flop resync, binary decode, per-cycle advance and multi-bit-step detection.
module gray_ptr_rx
   import gray_ptr_rx_pkg::*;
#(
   parameter int N   = PTR_W_DEF,
   parameter int ECW = 8
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic [N-1:0]   gray_in,
   input  logic           err_clr,
   output logic [N-1:0]   bin_out,
   output logic           bin_valid,
   output logic           upd,
   output logic [N-1:0]   delta,
   output logic           step_err,
   output logic [ECW-1:0] err_cnt
);

   localparam logic [1:0]     FILL_LAST = 2'(FILL_LEN - 1);
   localparam logic [ECW-1:0] ERR_MAX   = '1;

   logic [N-1:0]   s1_q, s2_q, s3_q;
   logic [N-1:0]   bin_q;
   logic [N-1:0]   delta_q, delta_d;
   logic           upd_q, upd_d;
   logic           step_err_q, step_err_d;
   logic [ECW-1:0] err_cnt_q, err_cnt_d;
   logic [1:0]     fill_cnt_q, fill_cnt_d;
   rx_state_e      state_q, state_d;

   logic [N-1:0]   s2_bin;
   logic [N-1:0]   diff;

   gray_ptr_rx_g2b #(.N(N)) u_g2b (
      .gray_i (s2_q),
      .bin_o  (s2_bin)
   );

   // bin_q always equals g2b(s3_q), so the advance is taken against bin_q.
   assign diff = s2_q ^ s3_q;

   // NOTE: every next-state signal gets a default first so no path infers a latch.
   always_comb begin
      state_d    = state_q;
      fill_cnt_d = fill_cnt_q;
      upd_d      = 1'b0;
      step_err_d = 1'b0;
      delta_d    = '0;
      err_cnt_d  = err_cnt_q;

      case (state_q)
         ST_FILL: begin
            fill_cnt_d = fill_cnt_q + 2'd1;
            if (fill_cnt_q == FILL_LAST) begin
               state_d = ST_TRACK;
            end
         end
         ST_TRACK: begin
            upd_d      = |diff;
            step_err_d = (diff & (diff - N'(1))) != '0;
            delta_d    = s2_bin - bin_q;
         end
         default: state_d = ST_FILL;
      endcase

      // Clear wins over a coincident error pulse.
      if (err_clr) begin
         err_cnt_d = '0;
      end else if (step_err_q && (err_cnt_q != ERR_MAX)) begin
         err_cnt_d = err_cnt_q + ECW'(1);
      end
   end

   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_q       <= '0;
         s2_q       <= '0;
         s3_q       <= '0;
         bin_q      <= '0;
         delta_q    <= '0;
         upd_q      <= 1'b0;
         step_err_q <= 1'b0;
         err_cnt_q  <= '0;
         fill_cnt_q <= 2'd0;
         state_q    <= ST_FILL;
      end else begin
         s1_q       <= gray_in;
         s2_q       <= s1_q;
         s3_q       <= s2_q;
         bin_q      <= s2_bin;
         delta_q    <= delta_d;
         upd_q      <= upd_d;
         step_err_q <= step_err_d;
         err_cnt_q  <= err_cnt_d;
         fill_cnt_q <= fill_cnt_d;
         state_q    <= state_d;
      end
   end

   assign bin_out   = bin_q;
   assign bin_valid = (state_q == ST_TRACK);
   assign upd       = upd_q;
   assign delta     = delta_q;
   assign step_err  = step_err_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_gray_ptr_rx.sv
// Bench for gray_ptr_rx: stimulus is expressed as binary pointer values, and the
// expected outputs come from a sample-history model in the binary domain.
module tb_gray_ptr_rx;

   localparam int N   = 9;
   localparam int ECW = 2;
   localparam int ERR_SAT = (1 << ECW) - 1;

   logic           clk = 1'b0;
   logic           rstn;
   logic [N-1:0]   gray_in;
   logic           err_clr;
   logic [N-1:0]   bin_out;
   logic           bin_valid;
   logic           upd;
   logic [N-1:0]   delta;
   logic           step_err;
   logic [ECW-1:0] err_cnt;

   int total = 0;
   int bad   = 0;

   // Model state: binary value sampled at each edge since reset, seeded with
   // the zeros the pipeline holds out of reset.
   logic [N-1:0] samp[$];
   int           edges;
   int           m_err;
   logic         m_step, m_upd, m_valid;
   logic [N-1:0] m_bin, m_delta;
   logic [N-1:0] cur;

   gray_ptr_rx #(.N(N), .ECW(ECW)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .gray_in   (gray_in),
      .err_clr   (err_clr),
      .bin_out   (bin_out),
      .bin_valid (bin_valid),
      .upd       (upd),
      .delta     (delta),
      .step_err  (step_err),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [N-1:0] to_gray(input logic [N-1:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      samp    = '{9'd0, 9'd0, 9'd0};
      edges   = 0;
      m_err   = 0;
      m_step  = 1'b0;
      m_upd   = 1'b0;
      m_valid = 1'b0;
      m_bin   = '0;
      m_delta = '0;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".bin_out"},   32'(bin_out),   32'(m_bin));
      check({tag, ".bin_valid"}, 32'(bin_valid), 32'(m_valid));
      check({tag, ".upd"},       32'(upd),       32'(m_upd));
      check({tag, ".delta"},     32'(delta),     32'(m_delta));
      check({tag, ".step_err"},  32'(step_err),  32'(m_step));
      check({tag, ".err_cnt"},   32'(err_cnt),   32'(m_err));
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".bin_out"},   32'(bin_out),   32'd0);
      check({tag, ".bin_valid"}, 32'(bin_valid), 32'd0);
      check({tag, ".upd"},       32'(upd),       32'd0);
      check({tag, ".delta"},     32'(delta),     32'd0);
      check({tag, ".step_err"},  32'(step_err),  32'd0);
      check({tag, ".err_cnt"},   32'(err_cnt),   32'd0);
   endtask

   // Present binary value b (as gray) for one edge, advance the model, check.
   task automatic tick(input string tag, input logic [N-1:0] b, input logic clr);
      logic [N-1:0] now_s, prev_s;
      gray_in = to_gray(b);
      err_clr = clr;
      cur     = b;
      @(posedge clk);
      edges++;
      samp.push_back(b);
      if (clr) m_err = 0;
      else if (m_step && m_err < ERR_SAT) m_err++;
      now_s   = samp[samp.size()-3];
      prev_s  = samp[samp.size()-4];
      m_bin   = now_s;
      m_valid = (edges >= 3);
      if (edges >= 4) begin
         m_upd   = (now_s != prev_s);
         m_step  = ($countones(to_gray(now_s) ^ to_gray(prev_s)) > 1);
         m_delta = now_s - prev_s;
      end else begin
         m_upd   = 1'b0;
         m_step  = 1'b0;
         m_delta = '0;
      end
      #1;
      check_all(tag);
   endtask

   initial begin
      int r;
      logic clr;

      // Reset held with a nonzero pointer on the input.
      rstn    = 1'b0;
      err_clr = 1'b0;
      gray_in = 9'b000000101;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_zero("in_reset");
      #3;
      rstn = 1'b1;
      for (int i = 0; i < 5; i++) tick("fill", 9'd6, 1'b0);

      // Counting 0..4 (the jump from 6 to 0 is itself a multi-bit step).
      for (int i = 0; i <= 4; i++) tick("count", 9'(i), 1'b0);
      repeat (3) tick("count_hold", 9'd4, 1'b0);
      tick("clr1", 9'd4, 1'b1);

      // Wrap 510 -> 511 -> 0.
      repeat (3) tick("to510", 9'd510, 1'b0);
      tick("clr2", 9'd510, 1'b1);
      tick("w511", 9'd511, 1'b0);
      tick("w0", 9'd0, 1'b0);
      repeat (3) tick("wrap_hold", 9'd0, 1'b0);
      check("wrap_bin", 32'(bin_out), 32'd0);

      // Glitch: gray 000000011 -> 000001101 (binary 2 -> 9).
      repeat (3) tick("pre_glitch", 9'd2, 1'b0);
      tick("clr3", 9'd2, 1'b1);
      repeat (3) tick("glitch_hold", 9'd2, 1'b0);
      tick("glitch", 9'd9, 1'b0);
      repeat (3) tick("glitch_after", 9'd9, 1'b0);
      check("glitch_cnt", 32'(err_cnt), 32'd1);

      // Five multi-bit jumps: counter saturates.
      for (int i = 0; i < 5; i++) tick("sat_jump", (i % 2 == 0) ? 9'd2 : 9'd9, 1'b0);
      repeat (4) tick("sat_hold", 9'd2, 1'b0);
      check("sat_cnt", 32'(err_cnt), 32'(ERR_SAT));

      // Clear coincident with a step_err pulse.
      tick("clr_jump", 9'd9, 1'b0);
      tick("clr_wait", 9'd9, 1'b0);
      tick("clr_wait", 9'd9, 1'b0);
      check("clr_pulse_present", 32'(step_err), 32'd1);
      tick("clr_with_err", 9'd9, 1'b1);
      check("clr_with_err_cnt", 32'(err_cnt), 32'd0);

      // Randomized walk: mostly legal single steps, occasional jumps and clears.
      for (int i = 0; i < 300; i++) begin
         r   = $urandom_range(0, 15);
         clr = ($urandom_range(0, 19) == 0);
         if (r == 0)      tick("rand", 9'($urandom_range(0, 511)), clr);
         else if (r < 8)  tick("rand", cur + 9'd1, clr);
         else if (r < 12) tick("rand", cur - 9'd1, clr);
         else             tick("rand", cur, clr);
      end

      // Asynchronous reset mid-operation, then refill with no false error.
      repeat (4) tick("to200", 9'd200, 1'b0);
      check("pre_rst_bin", 32'(bin_out), 32'd200);
      #3;
      rstn = 1'b0;
      #1;
      check_zero("async_rst");
      model_reset();
      #2;
      rstn = 1'b1;
      for (int i = 0; i < 6; i++) tick("refill", 9'd200, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
